// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8-bit UART receiver, 16x oversampling, mid-bit sampling.
//             Default frame is 8N1. Defining UART_RX_PARITY_EN adds one
//             even-parity bit after the data bits.
//  Ports    : clk_sys    - system clock (single clock domain)
//             rst        - synchronous active-high reset
//             rxd        - asynchronous serial input, idle high
//             rx_data    - last good byte, held between strobes
//             rx_vld     - 1-cycle strobe, new rx_data
//             frame_err  - 1-cycle strobe, stop bit sampled low
//             parity_err - 1-cycle strobe, parity mismatch (0 without parity)
//  Params   : CLK_DIV    - clk_sys cycles per oversample tick (2..65535)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [15:0] c_div_last = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_rxd_meta;
  logic        r_rxd_s;
  logic        r_rxd_prev;
  logic [1:0]  r_sync_vld;
  logic        r_armed;
  logic [15:0] r_div;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bad;
`endif

  logic w_tick;
  logic w_fall;
  logic w_mid_start;
  logic w_mid_bit;

  assign w_tick      = (r_div == c_div_last);
  // The synchronizer resets to 1, so a line that is low when reset releases
  // would otherwise look like a falling edge. Edges only count once the real
  // line level has propagated through and been seen high at least once.
  assign w_fall      = r_armed & r_rxd_prev & ~r_rxd_s;
  // Start bit: 8 ticks after the edge is its midpoint.
  assign w_mid_start = w_tick && (r_tick_cnt == 4'd7);
  // The tick count is re-zeroed at the start-bit midpoint, so each wrap of
  // the 16-tick count lands on the midpoint of the following bit.
  assign w_mid_bit   = w_tick && (r_tick_cnt == 4'd15);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rxd_prev <= 1'b1;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
      r_div      <= 16'd0;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      rx_data    <= 8'h00;
      rx_vld     <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_s    <= r_rxd_meta;
      r_rxd_prev <= r_rxd_s;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1] && r_rxd_s) begin
        r_armed <= 1'b1;
      end

      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      // Divider and tick count sit at 0 in IDLE so a frame always starts
      // its timing from the detected edge.
      if (r_state == IDLE) begin
        r_div      <= 16'd0;
        r_tick_cnt <= 4'd0;
      end else begin
        r_div <= w_tick ? 16'd0 : r_div + 16'd1;
        if (w_tick) begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
        end
      end

      case (r_state)
        IDLE: begin
          r_bit_cnt <= 3'd0;
          if (w_fall) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_mid_start) begin
            if (r_rxd_s) begin
              r_state <= IDLE;
            end else begin
              r_tick_cnt <= 4'd0;
              r_state    <= DATA;
            end
          end
        end
        DATA: begin
          if (w_mid_bit) begin
            r_shift   <= {r_rxd_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_mid_bit) begin
            // Even parity: data bits plus parity bit must XOR to 0.
            r_par_bad <= ^{r_shift, r_rxd_s};
            r_state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_mid_bit) begin
            if (r_rxd_s) begin
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                parity_err <= 1'b1;
              end else begin
                rx_data <= r_shift;
                rx_vld  <= 1'b1;
              end
`else
              rx_data <= r_shift;
              rx_vld  <= 1'b1;
`endif
              r_state <= IDLE;
            end else begin
              // Bad stop bit wins over any parity result.
              frame_err <= 1'b1;
              r_state   <= WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          // A held-low (break) line gives a single frame_err.
          if (r_rxd_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
